adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Sits directly downstream of the dual-channel ADC front-end; consumes its two 12-bit single-clock-domain sample streams.
- Records a triggered snapshot of both channels into on-chip RAM, with a programmable pre-trigger window.
- Exposes the snapshot to the CPU through CSR fields: arm/trigger/config in, status and random-access readout out.

Parameters:
- ADC_W, 12, sample width per channel (unsigned offset-binary)
- DEPTH_LOG2, 10, log2 of snapshot depth; DEPTH = 2**DEPTH_LOG2 sample pairs

Ports:
- sys_clk  in  1  system clock; all logic single-domain
- sys_rst  in  1  reset, synchronous, active-high
- ch0_in  in  ADC_W  channel-1 sample, new value every sys_clk
- ch1_in  in  ADC_W  channel-2 sample, new value every sys_clk
- arm  in  1  single-cycle pulse: start a capture
- force_trig  in  1  single-cycle pulse: software trigger
- trig_src  in  1  0 = trigger on ch0_in, 1 = trigger on ch1_in
- trig_edge  in  1  0 = rising, 1 = falling
- trig_level  in  ADC_W  trigger threshold
- pre_len  in  DEPTH_LOG2  samples kept before the trigger
- busy  out  1  capture in progress
- done  out  1  snapshot complete and frozen
- start_ptr  out  DEPTH_LOG2  physical RAM address of the oldest snapshot sample
- rd_addr  in  DEPTH_LOG2  logical read index, 0 = oldest sample
- rd_data  out  2*ADC_W  {ch1, ch0} at rd_addr

Behaviour:
- Reset values: state IDLE, busy=0, done=0, start_ptr=0, rd_data=0, write pointer 0, prev_valid=0. RAM contents are not reset.
- Sample strobe: every cycle, or per the optional decimator. Writes, counters and trigger compare act only on strobe cycles.
- IDLE: no writes. arm -> PRE; wr_ptr=0, cnt=0, prev_valid=0.
- PRE: write {ch1,ch0} at wr_ptr, wr_ptr++ (wraps mod DEPTH), cnt++. When cnt reaches pre_len_eff -> TRIG_WAIT. pre_len_eff = min(pre_len, DEPTH-1), latched at arm. pre_len=0 goes straight from arm to TRIG_WAIT.
- TRIG_WAIT: keep writing circularly. Trigger is evaluated on the selected channel, unsigned compare:
  - rising: prev < level and cur >= level
  - falling: prev > level and cur <= level
  - requires prev_valid
  - force_trig also triggers, whether or not a strobe is present; it is ignored in IDLE, PRE and DONE.
- On trigger:
  - the triggering sample is written at wr_ptr
  - start_ptr = wr_ptr - pre_len_eff (mod DEPTH)
  - remaining = DEPTH - pre_len_eff - 1
  - next state POST; if remaining = 0, next state DONE
- POST: write, wr_ptr++, remaining-- per strobe. Leave for DONE on the strobe where remaining reaches 0.
- DONE: done=1, no writes, snapshot frozen.
- Status outputs: busy=1 in PRE, TRIG_WAIT and POST. done is cleared by arm or reset.
- arm in any state, including mid-capture, restarts from the PRE entry actions and clears done the following cycle.
- Edge history: prev and prev_valid update on every strobe in PRE, TRIG_WAIT and POST.
- Readout:
  - physical address = start_ptr + rd_addr (mod DEPTH), registered
  - RAM read registered
  - rd_data valid 2 cycles after rd_addr changes
  - reads allowed at any time; contents are meaningful only when done=1
- Reset mid-capture: return to IDLE next cycle, outputs to reset values.

Optional Feature:
- Macro: ADC_CAPTURE_DECIM_EN.
- With the macro:
  - adds port decim, in, 8, decimation ratio minus 1
  - an 8-bit counter produces a strobe every decim+1 cycles
  - counter resets on arm and on sys_rst
  - decim=0 means every cycle
  - decim is sampled at arm
- Without the macro: no decim port; strobe is tied to 1 every cycle.

Decomposition:
- Shared package adc_capture_pkg:
  - ADC_W constant
  - state enum cap_state_t {IDLE, PRE, TRIG_WAIT, POST, DONE}
  - sample-pair typedef, packed struct {ch1, ch0}
- Sub-module capture_ram: simple dual-port inferred BRAM
  - one write port, one registered read port
  - width 2*ADC_W, depth DEPTH

Test Plan:
- Ramp, then arm: ch0 = cycle count mod 4096; pre_len=16, level=0x800, rising, src=0. Required: done; start_ptr = trigger address - 16; rd_addr=16 returns ch0=0x800; rd_addr=0 returns 0x7F0.
- pre_len=0 plus force_trig 3 cycles after arm. Required: rd_addr=0 equals the sample at the force cycle; done after exactly 1024 strobes.
- pre_len=1023 (DEPTH-1), falling trigger crossing 0x400. Required: trigger sample at rd_addr=1023; remaining=0 means done the cycle after the trigger.
- Level held constant above threshold immediately after arm. Required: no trigger, since the first sample only sets prev and no crossing occurs; busy stays 1.
- Re-arm mid-POST. Required: done=0, state PRE, wr_ptr=0.
- sys_rst mid-TRIG_WAIT. Required: busy=0, done=0, start_ptr=0, rd_data=0 next cycle.
- With ADC_CAPTURE_DECIM_EN, decim=3 and a ramp input. Required: consecutive snapshot entries differ by 4.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types for the dual-channel ADC snapshot block.
// Holds the FSM state enum, the sample-pair layout and the edge detector.
package adc_capture_pkg;

  localparam int ADC_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    TRIG_WAIT,
    POST,
    DONE
  } cap_state_t;

  typedef struct packed {
    logic [ADC_W-1:0] ch1;
    logic [ADC_W-1:0] ch0;
  } sample_pair_t;

  function automatic logic edge_hit(
    input logic [ADC_W-1:0] prev,
    input logic [ADC_W-1:0] cur,
    input logic [ADC_W-1:0] level,
    input logic             falling
  );
    if (falling)
      return (prev > level) && (cur <= level);
    return (prev < level) && (cur >= level);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port snapshot RAM.
// One write port, one registered read port with a clearable output.
module capture_ram #(
  parameter int W  = 24,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd <= '0;
    else
      rd <= mem[ra];
  end

endmodule

// File: rtl/adc_capture.sv
// adc_capture: triggered dual-channel ADC snapshot into on-chip RAM.
// Define ADC_CAPTURE_DECIM_EN to add the decim port and sample decimator.
module adc_capture #(
  parameter int ADC_W      = 12,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [ADC_W-1:0]      ch0_in,
  input  logic [ADC_W-1:0]      ch1_in,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic                  trig_src,
  input  logic                  trig_edge,
  input  logic [ADC_W-1:0]      trig_level,
  input  logic [DEPTH_LOG2-1:0] pre_len,
`ifdef ADC_CAPTURE_DECIM_EN
  input  logic [7:0]            decim,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] start_ptr,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [2*ADC_W-1:0]    rd_data
);

  import adc_capture_pkg::*;

  localparam int AW = DEPTH_LOG2;
  localparam logic [AW-1:0] LAST = '1;

  cap_state_t state, state_d;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    pre_eff;
  logic [AW-1:0]    remaining;
  logic [AW-1:0]    rd_phys;
  logic [ADC_W-1:0] prev;
  logic [ADC_W-1:0] cur;
  logic             prev_valid;
  logic             strobe;
  logic             we;
  logic             trig;
  sample_pair_t     pair;

`ifdef ADC_CAPTURE_DECIM_EN
  logic [7:0] dcnt;
  logic [7:0] decim_q;

  assign strobe = (dcnt == decim_q);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dcnt    <= '0;
      decim_q <= '0;
    end else if (arm) begin
      dcnt    <= '0;
      decim_q <= decim;
    end else begin
      dcnt <= strobe ? 8'd0 : dcnt + 8'd1;
    end
  end
`else
  assign strobe = 1'b1;
`endif

  assign cur  = trig_src ? ch1_in : ch0_in;
  assign pair = {ch1_in, ch0_in};
  assign trig = force_trig |
    (strobe & prev_valid &
     edge_hit(prev, cur, trig_level, trig_edge));

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (arm) begin
      state_d = (pre_len == '0) ? TRIG_WAIT : PRE;
    end else begin
      unique case (state)
        PRE:
          if (strobe && (cnt + AW'(1) == pre_eff))
            state_d = TRIG_WAIT;
        TRIG_WAIT:
          if (trig)
            state_d = (pre_eff == LAST) ? DONE : POST;
        POST:
          if (strobe && (remaining == AW'(1)))
            state_d = DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    we   = 1'b0;
    unique case (state)
      PRE, POST: begin
        busy = 1'b1;
        we   = strobe;
      end
      TRIG_WAIT: begin
        busy = 1'b1;
        we   = strobe | force_trig;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
    if (arm || sys_rst)
      we = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      pre_eff    <= '0;
      remaining  <= '0;
      start_ptr  <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (arm) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      pre_eff    <= pre_len;
      prev_valid <= 1'b0;
    end else begin
      if (we)
        wr_ptr <= wr_ptr + AW'(1);
      if (state == PRE && strobe)
        cnt <= cnt + AW'(1);
      if (busy && strobe) begin
        prev       <= cur;
        prev_valid <= 1'b1;
      end
      // The window start is fixed relative to the triggering write.
      if (state == TRIG_WAIT && trig) begin
        start_ptr <= wr_ptr - pre_eff;
        remaining <= LAST - pre_eff;
      end else if (state == POST && strobe) begin
        remaining <= remaining - AW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      rd_phys <= '0;
    else
      rd_phys <= start_ptr + rd_addr;
  end

  capture_ram #(
    .W  (2*ADC_W),
    .AW (AW)
  ) u_ram (
    .clk (sys_clk),
    .rst (sys_rst),
    .we  (we),
    .wa  (wr_ptr),
    .wd  (pair),
    .ra  (rd_phys),
    .rd  (rd_data)
  );

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed and randomized checks of adc_capture.
// Snapshot contents are predicted from a recorded input history.
module tb_adc_capture;
  import adc_capture_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [11:0] ch0_in = '0;
  logic [11:0] ch1_in = '0;
  logic        arm = 1'b0;
  logic        force_trig = 1'b0;
  logic        trig_src = 1'b0;
  logic        trig_edge = 1'b0;
  logic [11:0] trig_level = '0;
  logic [9:0]  pre_len = '0;
  logic        busy;
  logic        done;
  logic [9:0]  start_ptr;
  logic [9:0]  rd_addr = '0;
  logic [23:0] rd_data;
`ifdef ADC_CAPTURE_DECIM_EN
  logic [7:0]  decim = '0;
`endif

  adc_capture dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .ch0_in     (ch0_in),
    .ch1_in     (ch1_in),
    .arm        (arm),
    .force_trig (force_trig),
    .trig_src   (trig_src),
    .trig_edge  (trig_edge),
    .trig_level (trig_level),
    .pre_len    (pre_len),
`ifdef ADC_CAPTURE_DECIM_EN
    .decim      (decim),
`endif
    .busy       (busy),
    .done       (done),
    .start_ptr  (start_ptr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          mode = 1;
  logic [11:0] hold_v = '0;
  logic [23:0] hist[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Next-edge input values; index cyc is the edge they will be seen at.
  task automatic drive();
    logic [31:0] c;
    c = cyc;
    case (mode)
      0: begin
        ch0_in = c[11:0];
        ch1_in = 12'($urandom);
      end
      1: begin
        ch0_in = 12'($urandom);
        ch1_in = 12'($urandom);
      end
      default: begin
        ch0_in = hold_v;
        ch1_in = hold_v;
      end
    endcase
  endtask

  task automatic step();
    @(posedge sys_clk);
    hist.push_back({ch1_in, ch0_in});
    cyc++;
    #1;
    arm = 1'b0;
    force_trig = 1'b0;
    drive();
  endtask

  task automatic read_one(input int a, output logic [23:0] v);
    rd_addr = 10'(a);
    step();
    step();
    v = rd_data;
  endtask

  function automatic logic [11:0] sel(int k, logic src);
    logic [23:0] s;
    s = hist[k];
    return src ? s[23:12] : s[11:0];
  endfunction

  // First edge at which the snapshot trigger should fire.
  function automatic int find_trig(int w0, int p, logic src,
                                   logic fall, logic [11:0] lvl,
                                   int fe);
    logic [11:0] a, b;
    for (int t = w0 + p; t < hist.size(); t++) begin
      if (t == fe) return t;
      if (t - 1 >= w0) begin
        a = sel(t - 1, src);
        b = sel(t, src);
        if (!fall && a < lvl && b >= lvl) return t;
        if (fall && a > lvl && b <= lvl) return t;
      end
    end
    return -1;
  endfunction

  task automatic capture(string tag, int p, logic src, logic fall,
                         logic [11:0] lvl, int fofs, output int t);
    int a, fe, d, w0, nbad;
    pre_len = 10'(p);
    trig_src = src;
    trig_edge = fall;
    trig_level = lvl;
    a = cyc;
    fe = (fofs < 0) ? -1 : a + fofs;
    arm = 1'b1;
    step();
    d = -1;
    for (int j = 0; j < 6000 && d < 0; j++) begin
      if (cyc == fe) force_trig = 1'b1;
      step();
      if (done) d = cyc - 1;
    end
    w0 = a + 1;
    t = find_trig(w0, p, src, fall, lvl, fe);
    chk({tag, " trig_found"}, 32'(t >= 0), 1);
    chk({tag, " done_edge"}, d, t + 1023 - p);
    chk({tag, " start_ptr"}, 32'(start_ptr), (t - p - w0) & 1023);
    nbad = 0;
    for (int i = 0; i <= 1024; i++) begin
      if (i < 1024) rd_addr = 10'(i);
      step();
      if (i >= 1 && t >= 0 && rd_data !== hist[t - p + i - 1])
        nbad++;
    end
    chk({tag, " snapshot_bad"}, nbad, 0);
  endtask

  initial begin
    int t, a;
    logic [23:0] v, w;

    drive();
    step();
    step();
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst start_ptr", 32'(start_ptr), 0);
    chk("rst rd_data", 32'(rd_data), 0);
    chk("rst state", 32'(dut.state), 32'(IDLE));
    sys_rst = 1'b0;
    step();

    mode = 0;
    capture("ramp", 16, 1'b0, 1'b0, 12'h800, -1, t);
    read_one(16, v);
    chk("ramp addr16", 32'(v[11:0]), 32'h800);
    read_one(0, v);
    chk("ramp addr0", 32'(v[11:0]), 32'h7F0);

    mode = 1;
    capture("force", 0, 1'b0, 1'b0, 12'h000, 3, t);
    read_one(0, v);
    chk("force addr0", 32'(v), 32'(hist[t]));

    capture("pre_max", 1023, 1'b1, 1'b1, 12'h400, -1, t);
    read_one(1023, v);
    chk("pre_max addr1023", 32'(v), 32'(hist[t]));

    mode = 2;
    hold_v = 12'h900;
    pre_len = 10'd4;
    trig_src = 1'b0;
    trig_edge = 1'b0;
    trig_level = 12'h800;
    arm = 1'b1;
    step();
    for (int i = 0; i < 200; i++) step();
    chk("hold busy", 32'(busy), 1);
    chk("hold done", 32'(done), 0);
    chk("hold state", 32'(dut.state), 32'(TRIG_WAIT));

    mode = 1;
    pre_len = 10'd8;
    trig_level = 12'h000;
    a = cyc;
    arm = 1'b1;
    step();
    for (int i = 0; i < 70; i++) begin
      if (cyc == a + 20) force_trig = 1'b1;
      step();
    end
    chk("rearm pre state", 32'(dut.state), 32'(POST));
    arm = 1'b1;
    step();
    chk("rearm done", 32'(done), 0);
    chk("rearm busy", 32'(busy), 1);
    chk("rearm state", 32'(dut.state), 32'(PRE));
    chk("rearm wr_ptr", 32'(dut.wr_ptr), 0);
    for (int i = 0; i < 10; i++) step();
    chk("rearm twait", 32'(dut.state), 32'(TRIG_WAIT));

    sys_rst = 1'b1;
    step();
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst start_ptr", 32'(start_ptr), 0);
    chk("midrst rd_data", 32'(rd_data), 0);
    chk("midrst state", 32'(dut.state), 32'(IDLE));
    sys_rst = 1'b0;
    step();

    for (int k = 0; k < 2; k++) begin
      capture("random", $urandom_range(1, 1022),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              12'($urandom_range(12'h100, 12'hEFF)), -1, t);
    end

`ifdef ADC_CAPTURE_DECIM_EN
    mode = 0;
    decim = 8'd3;
    pre_len = 10'd0;
    trig_level = 12'h000;
    trig_edge = 1'b0;
    a = cyc;
    arm = 1'b1;
    step();
    for (int j = 0; j < 6000 && !done; j++) begin
      if (cyc == a + 12) force_trig = 1'b1;
      step();
    end
    chk("decim done", 32'(done), 1);
    read_one(0, w);
    for (int i = 1; i < 8; i++) begin
      read_one(i, v);
      chk("decim step", 32'((v[11:0] - w[11:0]) & 12'hFFF), 4);
      w = v;
    end
    decim = 8'd0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
